dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Two-port arbiter and access sequencer in front of the `dmem` data memory. It accepts byte-addressed load/store requests from the CPU pipeline (port 0) and from the debug/program loader (port 1), and arbitrates between them round-robin. For each granted request it drives the `dmem` control signals (`dm_w`, `dm_r`, `store_format_signal`, `detail_pos`, `dm_addr`). It returns aligned, sign- or zero-extended load data, or an error for misaligned or illegal accesses.

## Interface
- `AW`, default 11: word-address width; byte address width is `AW+2`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0`/`req1` in 1: access request; held stable until `gnt` for that port.
- `we0`/`we1` in 1: 1 = store, 0 = load.
- `size0`/`size1` in 2: access size. 00 = word, 01 = half, 10 = byte, 11 = illegal.
- `sext0`/`sext1` in 1: sign-extend load result (lb/lh); ignored for word loads and for stores.
- `addr0`/`addr1` in AW+2: byte address.
- `wdata0`/`wdata1` in 32: store data, right-justified.
- `gnt0`/`gnt1` out 1: one-cycle pulse; request captured.
- `rvalid0`/`rvalid1` out 1: one-cycle completion pulse for loads and stores.
- `rdata0`/`rdata1` out 32: load result; 0 for stores and errors.
- `err0`/`err1` out 1: valid with `rvalid`; misaligned access or illegal size.
- `dm_w`, `dm_r` out 1: `dmem` write/read enables.
- `store_format_signal` out 2: equals the captured size.
- `detail_pos` out 2: equals the captured `addr[1:0]`.
- `dm_addr` out AW: equals the captured `addr[AW+1:2]`.
- `dm_wdata` out 32: captured wdata.
- `dm_rdata` in 32: `dmem` read data, combinational from `dm_addr`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `req` is high, grant one port. `gnt` pulses and the command is captured. Next state: ACCESS.
- ACCESS: drive `dmem` for exactly one cycle.
  - Load: `dm_r=1`; capture the extracted data at the clock edge.
  - Store: `dm_w=1`; the write commits at this edge.
  - Next state: RESP.
- RESP: pulse `rvalid` and `err` on the captured port; `rdata` is held from the capture. Next state: IDLE.
- Arbitration:
  - Round-robin with a last-grant pointer, reset value 1, so port 0 wins the first contest.
  - A lone requester always wins.
  - On simultaneous requests, the port not granted last wins.
- Error checks:
  - size 11 → error.
  - half with `addr[0]=1` → error.
  - word with `addr[1:0]≠0` → error.
  - On error, ACCESS keeps `dm_w=dm_r=0` (no memory side effect), and RESP gives `err=1`, `rdata=0`.
- Load extraction:
  - word → `dm_rdata`.
  - half → `addr[1]` ? [31:16] : [15:0].
  - byte → the lane at `addr[1:0]`.
  - Extend to 32 bits with sign if `sext`, else with zeros.
- `dm_*` outputs are registered from the captured command. They are 0 outside ACCESS, except `dm_addr`, `dm_wdata`, `store_format_signal` and `detail_pos`, which may hold their last value.

## Timing
- Request seen in cycle N (IDLE) → `gnt` in cycle N → `dm_r`/`dm_w` in N+1 → `rvalid` in N+2.
- Fixed 3-cycle occupancy; peak throughput is one access per 3 cycles.
- Requests arriving during ACCESS or RESP wait; `gnt` is never issued outside IDLE.
- `req` dropped before `gnt`: ignored, no side effect.
- Reset values: all outputs 0, state IDLE, pointer 1.
- Reset asserted mid-operation:
  - `dm_w` clears immediately and asynchronously. A store whose ACCESS edge has not yet occurred is not committed.
  - The pending response is discarded; no `rvalid` is issued.
- Back-to-back: a request held high through RESP is granted in the following IDLE cycle.

## Structure
- Package `dmem_pkg`:
  - `SZ_WORD`/`SZ_HALF`/`SZ_BYTE`/`SZ_ILL` size encodings, shared with the decode stage and `dmem`.
  - FSM state enum.
  - Captured-command struct: port, we, size, sext, addr, wdata.
- Sub-module `dmem_load_align`: combinational lane select and extension from (`dm_rdata`, size, `addr[1:0]`, `sext`).
- The misalignment check lives in the top module.

## Test plan
- Port 0 stores word 0x89ABCDEF at byte 0x010. Port 0 then loads word at 0x010. Required: `dm_w` pulses with `dm_addr=4`, `store_format_signal=00`; the load gives `rvalid0` at N+2 with `rdata0=0x89ABCDEF`, `err0=0`.
- After that word: lb sext at 0x013 → 0xFFFFFF89; lbu at 0x013 → 0x00000089; lh sext at 0x012 → 0xFFFF89AB; lhu at 0x010 → 0x0000CDEF.
- Store byte 0x55 at 0x011 then load word at 0x010 → 0x89AB55EF, with `detail_pos=01` during the store.
- `req0` and `req1` held high together for 4 accesses: grant order 0,1,0,1. Each `rvalid` goes only to its own port, 3 cycles apart.
- Illegal and misaligned accesses each give `err=1` with `dm_w` and `dm_r` never asserted, and a following load shows memory unchanged:
  - half store at 0x021;
  - word load at 0x022;
  - size 11.
- Reset: assert `rst_n=0` in the store's ACCESS cycle before the edge, then release. Required: all outputs 0, no `rvalid`, and a subsequent load returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and types for the dmem access path.
package dmem_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // Widest byte address the captured command can hold; top zero-pads into it.
   localparam int CMD_AW = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   typedef struct packed {
      logic              port;
      logic              we;
      logic [1:0]        size;
      logic              sext;
      logic [CMD_AW-1:0] addr;
      logic [31:0]       wdata;
   } cmd_t;

endpackage

// File: rtl/dmem_load_align.sv
// Lane select and sign/zero extension of dmem read data for loads.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  pos_i,
   input  logic        sext_i,
   output logic [31:0] data_o
);

   logic [15:0] half;
   logic [7:0]  lane;

   always_comb begin
      half   = pos_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      lane   = rdata_i[{pos_i, 3'b000} +: 8];
      data_o = rdata_i;
      case (size_i)
         SZ_HALF: data_o = {{16{sext_i & half[15]}}, half};
         SZ_BYTE: data_o = {{24{sext_i & lane[7]}}, lane};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Round-robin two-port arbiter and fixed three-cycle access sequencer for dmem.
//  state  | meaning
//  IDLE   | waiting for a request; grant and capture command
//  ACCESS | dmem enables driven for one cycle; load data captured at the edge
//  RESP   | rvalid/err pulsed on the captured port
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [1:0]    size0,
   input  logic          sext0,
   input  logic [AW+1:0] addr0,
   input  logic [31:0]   wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [1:0]    size1,
   input  logic          sext1,
   input  logic [AW+1:0] addr1,
   input  logic [31:0]   wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [31:0]   rdata0,
   output logic [31:0]   rdata1,
   output logic          err0,
   output logic          err1,
   output logic          dm_w,
   output logic          dm_r,
   output logic [1:0]    store_format_signal,
   output logic [1:0]    detail_pos,
   output logic [AW-1:0] dm_addr,
   output logic [31:0]   dm_wdata,
   input  logic [31:0]   dm_rdata
);

   state_e      state_q, state_d;
   logic        last_q;
   cmd_t        cmd_q, sel_cmd;
   logic        err_q, sel_err;
   logic        dm_w_q, dm_r_q;
   logic [31:0] rdata_q, ld_data;
   logic        gnt_any, gnt_port;
   logic        unused_addr;

   always_comb begin
      state_d  = state_q;
      gnt_any  = 1'b0;
      gnt_port = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               gnt_any  = 1'b1;
               // Contested: the port that did not win last time goes first.
               gnt_port = (req0 && req1) ? ~last_q : req1;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sel_cmd       = '0;
      sel_cmd.port  = gnt_port;
      sel_cmd.we    = gnt_port ? we1    : we0;
      sel_cmd.size  = gnt_port ? size1  : size0;
      sel_cmd.sext  = gnt_port ? sext1  : sext0;
      sel_cmd.addr  = {{(CMD_AW-AW-2){1'b0}}, (gnt_port ? addr1 : addr0)};
      sel_cmd.wdata = gnt_port ? wdata1 : wdata0;
      case (sel_cmd.size)
         SZ_WORD: sel_err = (sel_cmd.addr[1:0] != 2'b00);
         SZ_HALF: sel_err = sel_cmd.addr[0];
         SZ_BYTE: sel_err = 1'b0;
         default: sel_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         cmd_q   <= '0;
         err_q   <= 1'b0;
         dm_w_q  <= 1'b0;
         dm_r_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (gnt_any) begin
            cmd_q  <= sel_cmd;
            err_q  <= sel_err;
            last_q <= gnt_port;
            dm_w_q <= sel_cmd.we & ~sel_err;
            dm_r_q <= ~sel_cmd.we & ~sel_err;
         end else begin
            dm_w_q <= 1'b0;
            dm_r_q <= 1'b0;
         end
         if (state_q == ST_ACCESS) begin
            rdata_q <= dm_r_q ? ld_data : '0;
         end
      end
   end

   dmem_load_align u_align (
      .rdata_i (dm_rdata),
      .size_i  (cmd_q.size),
      .pos_i   (cmd_q.addr[1:0]),
      .sext_i  (cmd_q.sext),
      .data_o  (ld_data)
   );

   assign gnt0 = gnt_any & ~gnt_port;
   assign gnt1 = gnt_any &  gnt_port;

   assign rvalid0 = (state_q == ST_RESP) & ~cmd_q.port;
   assign rvalid1 = (state_q == ST_RESP) &  cmd_q.port;
   assign err0    = rvalid0 & err_q;
   assign err1    = rvalid1 & err_q;
   assign rdata0  = cmd_q.port ? '0 : rdata_q;
   assign rdata1  = cmd_q.port ? rdata_q : '0;

   assign dm_w                = dm_w_q;
   assign dm_r                = dm_r_q;
   assign store_format_signal = cmd_q.size;
   assign detail_pos          = cmd_q.addr[1:0];
   assign dm_addr             = cmd_q.addr[AW+1:2];
   assign dm_wdata            = cmd_q.wdata;

   assign unused_addr = ^cmd_q.addr[CMD_AW-1:AW+2];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural dmem behind it.
module tb_dmem_ctrl;

   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 0, we0 = 0, sext0 = 0;
   logic          req1 = 0, we1 = 0, sext1 = 0;
   logic [1:0]    size0 = 0, size1 = 0;
   logic [AW+1:0] addr0 = 0, addr1 = 0;
   logic [31:0]   wdata0 = 0, wdata1 = 0;
   logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, dm_w, dm_r;
   logic [31:0]   rdata0, rdata1, dm_wdata, dm_rdata;
   logic [1:0]    store_format_signal, detail_pos;
   logic [AW-1:0] dm_addr;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          mem_clr = 1'b1;

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .size0(size0), .sext0(sext0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .size1(size1), .sext1(sext1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
      .dm_w(dm_w), .dm_r(dm_r), .store_format_signal(store_format_signal),
      .detail_pos(detail_pos), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
   );

   assign dm_rdata = mem[dm_addr];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
      end else if (dm_w) begin
         case (store_format_signal)
            2'b00: mem[dm_addr] <= dm_wdata;
            2'b01: if (detail_pos[1]) mem[dm_addr][31:16] <= dm_wdata[15:0];
                   else               mem[dm_addr][15:0]  <= dm_wdata[15:0];
            2'b10: mem[dm_addr][{detail_pos, 3'b000} +: 8] <= dm_wdata[7:0];
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] all_outs();
      return {gnt0, gnt1, rvalid0, rvalid1, err0, err1, dm_w, dm_r, rdata0, rdata1,
              dm_addr, dm_wdata, store_format_signal, detail_pos};
   endfunction

   // Runs one access from the given port, starting just after a rising edge in IDLE.
   task automatic acc(input string tag, input bit p, input bit we, input logic [1:0] sz,
                      input bit sx, input logic [AW+1:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_err);
      bit got = 0;
      if (!p) begin
         req0 = 1; we0 = we; size0 = sz; sext0 = sx; addr0 = a; wdata0 = wd;
      end else begin
         req1 = 1; we1 = we; size1 = sz; sext1 = sx; addr1 = a; wdata1 = wd;
      end
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         got = p ? gnt1 : gnt0;
      end
      chk({tag, " gnt"}, got, 1);
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      if (!got) return;
      @(negedge clk);
      chk({tag, " dm_w"}, dm_w, we & !exp_err);
      chk({tag, " dm_r"}, dm_r, !we & !exp_err);
      if (!exp_err)
         chk({tag, " dm_cmd"}, {dm_addr, store_format_signal, detail_pos}, {a[AW+1:2], sz, a[1:0]});
      @(negedge clk);
      chk({tag, " rvalid"}, {rvalid1, rvalid0}, p ? 2'b10 : 2'b01);
      chk({tag, " rdata"}, p ? rdata1 : rdata0, exp_rd);
      chk({tag, " err"}, p ? err1 : err0, exp_err);
      @(posedge clk); #1;
   endtask

   initial begin
      bit ok;
      repeat (3) @(posedge clk);
      #1;
      mem_clr = 0;
      chk("reset outs", all_outs(), '0);
      rst_n = 1;
      @(posedge clk); #1;

      // Both ports contend for four accesses: 0,1,0,1 with rvalids 2 cycles after each grant.
      req0 = 1; we0 = 0; size0 = 2'b00; addr0 = 13'h040;
      req1 = 1; we1 = 0; size1 = 2'b00; addr1 = 13'h044;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("arb c%0d", c), {gnt0, gnt1, rvalid0, rvalid1},
             {(c % 6 == 0), (c % 6 == 3), (c % 6 == 2), (c % 6 == 5)});
      end
      req0 = 0; req1 = 0;
      @(posedge clk); #1;

      acc("sw",   0, 1, 2'b00, 0, 13'h010, 32'h89ABCDEF, 32'h0,        0);
      acc("lw",   0, 0, 2'b00, 0, 13'h010, 32'h0,        32'h89ABCDEF, 0);
      acc("lb",   0, 0, 2'b10, 1, 13'h013, 32'h0,        32'hFFFFFF89, 0);
      acc("lbu",  1, 0, 2'b10, 0, 13'h013, 32'h0,        32'h00000089, 0);
      acc("lh",   0, 0, 2'b01, 1, 13'h012, 32'h0,        32'hFFFF89AB, 0);
      acc("lhu",  1, 0, 2'b01, 0, 13'h010, 32'h0,        32'h0000CDEF, 0);
      acc("sb",   1, 1, 2'b10, 0, 13'h011, 32'h00000055, 32'h0,        0);
      acc("lw2",  0, 0, 2'b00, 0, 13'h010, 32'h0,        32'h89AB55EF, 0);

      acc("sw20", 1, 1, 2'b00, 0, 13'h020, 32'hDEADBEEF, 32'h0,        0);
      acc("sh_mis", 0, 1, 2'b01, 0, 13'h021, 32'h00001234, 32'h0,      1);
      acc("lw_mis", 1, 0, 2'b00, 0, 13'h022, 32'h0,        32'h0,      1);
      acc("sz_ill", 0, 1, 2'b11, 0, 13'h020, 32'h0,        32'h0,      1);
      acc("lw20", 0, 0, 2'b00, 0, 13'h020, 32'h0,        32'hDEADBEEF, 0);

      // Reset lands in the store's ACCESS cycle, before its committing edge.
      req0 = 1; we0 = 1; size0 = 2'b00; sext0 = 0; addr0 = 13'h010; wdata0 = 32'h11111111;
      ok = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         ok = gnt0;
      end
      chk("rst gnt", ok, 1);
      @(posedge clk); #1;
      req0 = 0;
      chk("rst pre dm_w", dm_w, 1);
      #5;
      rst_n = 0;
      #1;
      chk("rst outs", all_outs(), '0);
      @(posedge clk); #2;
      rst_n = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("rst no rvalid c%0d", c), {rvalid0, rvalid1}, 2'b00);
      end
      @(posedge clk); #1;
      acc("rst lw", 0, 0, 2'b00, 0, 13'h010, 32'h0, 32'h89AB55EF, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
